stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Parametrised successor to the stopwatch digit counter: a single-clock MM:SS BCD counter.
- Uses clock-enable strobes rather than clock muxing.
- Adds count-up/count-down modes, preset load with validity checking, and lap capture.
- Adds a countdown-expired flag and a configurable minute ceiling.
- Sits between the tick/debounce logic and the seven-segment display driver.

Parameters:
- MIN_MAX, 59: highest minute value before wrap. Legal range 1..99; minutes are two BCD digits.
- START_PAUSED, 0: value of paused after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low. 0 = reset.
- tick  in  1  one-cycle 1 Hz run strobe.
- adj_tick  in  1  one-cycle adjust-rate strobe.
- pause_btn  in  1  debounced level; its rising edge toggles paused.
- adjust  in  1  1 = adjust mode.
- select  in  1  in adjust mode, 1 = seconds field, 0 = minutes field.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  one-cycle strobe; loads the preset.
- preset  in  16  {min1,min0,sec1,sec0} BCD.
- lap  in  1  debounced level; its rising edge captures a lap.
- min1, min0, sec1, sec0  out  4 each  current BCD time.
- lap_time  out  16  captured {min1,min0,sec1,sec0}.
- lap_valid  out  1  a lap has been captured.
- paused  out  1  pause state.
- expired  out  1  countdown reached 00:00.
- load_err  out  1  one-cycle pulse when a preset is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - Time digits = 0, lap_time = 0.
  - lap_valid, expired and load_err = 0.
  - paused = START_PAUSED.
  - pause_btn and lap edge-detect registers = 0.
- All outputs are registered. A qualifying strobe at edge N is visible after edge N.
- Edge detect: rise = input & ~prev, with prev registered every cycle.
  - A pause rise toggles paused.
- Time-update priority per cycle, highest first:
  1. load.
  2. Adjust step: adjust=1 & adj_tick. Allowed while paused.
  3. Run step: adjust=0 & tick & ~paused. Uses the paused value registered before this edge.
  4. Hold.
- When adjust=1, tick is ignored. When adjust=0, adj_tick is ignored.
- Load:
  - Preset is valid if every digit is ≤9, sec1 ≤5, and the minute value is ≤MIN_MAX.
  - Valid: time = preset; expired = 0; lap_valid = 0.
  - Invalid: time unchanged; load_err = 1 for one cycle.
- Run step, up (mode=0):
  - sec0 increments 9→0 with carry into sec1; sec1 5→0 with carry into minutes.
  - min0 increments 9→0 with carry into min1.
  - At MIN_MAX:59 the next step goes to 00:00 (rollover; expired unaffected).
- Run step, down (mode=1):
  - If time ≠ 00:00: sec0 decrements 0→9 with borrow; sec 00→59 with borrow from minutes.
  - If the decrement lands on 00:00, set expired in the same edge.
  - If time = 00:00: hold and set expired.
  - No wrap below 00:00.
- Adjust step:
  - select=1: seconds field increments 00..59, then wraps to 00 with no carry into minutes.
  - select=0: minutes field increments 00..MIN_MAX, then wraps to 00. Seconds are untouched.
  - The step is always an increment, independent of mode.
  - Any adjust step clears expired.
- expired is sticky. It clears on reset, valid load, adjust step, or mode=0 sampled at any edge.
- Lap:
  - A rise captures the time registered before the edge (the pre-update value if a step happens in the same cycle).
  - lap_valid = 1 until reset or valid load.
  - A new rise overwrites lap_time.
- Simultaneous events:
  - pause rise and tick in the same cycle: the step uses the old paused value, and paused toggles at that edge.
  - load and lap rise in the same cycle: the lap captures the old time, then the load's lap_valid clear wins.
- Minute arithmetic uses a 7-bit binary compare against MIN_MAX, derived as min1*10+min0.

Test Plan:
- Reset, then mode=0, with 60 ticks → 00:00 → 01:00. MIN_MAX=59 preset 59:59 plus one tick → 00:00, expired=0.
- mode=1, preset 00:02, three ticks → 00:01, then 00:00 with expired=1 on the second tick. The third tick holds 00:00 with expired=1.
- mode=1, preset 01:00, one tick → 00:59.
- pause_btn rise with tick in the same cycle → that step executes, paused=1. Five further ticks leave the time unchanged. Adjust with select=1 while paused, five adj_ticks from 00:57 → 00:58, 00:59, 00:00, 00:01, 00:02; minutes unchanged.
- Preset 0x6012 with MIN_MAX=59 → load_err pulse, time unchanged. Preset 0x1A00 → rejected. Preset 0x4530 → accepted.
- Time 12:34 with lap rise and tick in the same cycle → lap_time=0x1234, time=12:35, lap_valid=1. Then a valid load → lap_valid=0.
- Assert reset low mid-count at 07:42, asynchronously between clock edges → outputs are 0 immediately. After release, paused = START_PAUSED.

Source files
------------

// File: rtl/stopwatch_if.sv
// Stopwatch control/status bundle between tick logic and display driver.
// master drives strobes/levels/preset; slave returns time, lap and flags.
interface stopwatch_if;
    logic        tick;
    logic        adj_tick;
    logic        pause_btn;
    logic        adjust;
    logic        select;
    logic        mode;
    logic        load;
    logic [15:0] preset;
    logic        lap;
    logic [3:0]  min1;
    logic [3:0]  min0;
    logic [3:0]  sec1;
    logic [3:0]  sec0;
    logic [15:0] lap_time;
    logic        lap_valid;
    logic        paused;
    logic        expired;
    logic        load_err;

    modport master (
        output tick, adj_tick, pause_btn, adjust, select, mode,
        output load, preset, lap,
        input  min1, min0, sec1, sec0, lap_time, lap_valid,
        input  paused, expired, load_err
    );

    modport slave (
        input  tick, adj_tick, pause_btn, adjust, select, mode,
        input  load, preset, lap,
        output min1, min0, sec1, sec0, lap_time, lap_valid,
        output paused, expired, load_err
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch: up/down run, adjust, preset load, lap, expiry.
// Ports: clk, reset (async active-low), sw (stopwatch_if.slave bundle).
module stopwatch_core #(
    parameter int MIN_MAX      = 59,
    parameter bit START_PAUSED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    stopwatch_if.slave sw
);
    localparam logic [6:0] MAXB = 7'(MIN_MAX);

    logic [3:0]  min1_q, min0_q, sec1_q, sec0_q;
    logic [3:0]  min1_d, min0_d, sec1_d, sec0_d;
    logic [15:0] lap_q, lap_d;
    logic        lapv_q, lapv_d;
    logic        paused_q, paused_d;
    logic        exp_q, exp_d;
    logic        lerr_q, lerr_d;
    logic        pbtn_q, lbtn_q;

    logic        pause_rise, lap_rise;
    logic        preset_ok;
    logic [6:0]  min_val, pre_min;
    logic [15:0] time_q;

    assign time_q  = {min1_q, min0_q, sec1_q, sec0_q};
    assign min_val = 7'(min1_q) * 7'd10 + 7'(min0_q);
    // Truncation for digits >9 is harmless: the digit checks reject those.
    assign pre_min = 7'(sw.preset[15:12]) * 7'd10 + 7'(sw.preset[11:8]);

    assign pause_rise = sw.pause_btn & ~pbtn_q;
    assign lap_rise   = sw.lap & ~lbtn_q;

    assign preset_ok = (sw.preset[15:12] <= 4'd9) &&
                       (sw.preset[11:8]  <= 4'd9) &&
                       (sw.preset[7:4]   <= 4'd5) &&
                       (sw.preset[3:0]   <= 4'd9) &&
                       (pre_min <= MAXB);

    always_comb begin
        min1_d   = min1_q;
        min0_d   = min0_q;
        sec1_d   = sec1_q;
        sec0_d   = sec0_q;
        lap_d    = lap_q;
        lapv_d   = lapv_q;
        lerr_d   = 1'b0;
        paused_d = paused_q ^ pause_rise;
        // Leaving down mode clears the sticky expiry flag.
        exp_d    = exp_q & sw.mode;

        // Lap samples the pre-update time; a valid load below may clear lapv.
        if (lap_rise) begin
            lap_d  = time_q;
            lapv_d = 1'b1;
        end

        if (sw.load) begin
            if (preset_ok) begin
                {min1_d, min0_d, sec1_d, sec0_d} = sw.preset;
                exp_d  = 1'b0;
                lapv_d = 1'b0;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (sw.adjust && sw.adj_tick) begin
            exp_d = 1'b0;
            if (sw.select) begin
                if (sec1_q == 4'd5 && sec0_q == 4'd9) begin
                    sec1_d = 4'd0;
                    sec0_d = 4'd0;
                end else if (sec0_q == 4'd9) begin
                    sec0_d = 4'd0;
                    sec1_d = sec1_q + 4'd1;
                end else begin
                    sec0_d = sec0_q + 4'd1;
                end
            end else begin
                if (min_val >= MAXB) begin
                    min1_d = 4'd0;
                    min0_d = 4'd0;
                end else if (min0_q == 4'd9) begin
                    min0_d = 4'd0;
                    min1_d = min1_q + 4'd1;
                end else begin
                    min0_d = min0_q + 4'd1;
                end
            end
        end else if (!sw.adjust && sw.tick && !paused_q) begin
            if (!sw.mode) begin
                if (sec0_q != 4'd9) begin
                    sec0_d = sec0_q + 4'd1;
                end else begin
                    sec0_d = 4'd0;
                    if (sec1_q != 4'd5) begin
                        sec1_d = sec1_q + 4'd1;
                    end else begin
                        sec1_d = 4'd0;
                        if (min_val >= MAXB) begin
                            min1_d = 4'd0;
                            min0_d = 4'd0;
                        end else if (min0_q == 4'd9) begin
                            min0_d = 4'd0;
                            min1_d = min1_q + 4'd1;
                        end else begin
                            min0_d = min0_q + 4'd1;
                        end
                    end
                end
            end else if (time_q == 16'h0000) begin
                exp_d = 1'b1;
            end else begin
                // 00:01 is the only value whose decrement lands on 00:00.
                if (time_q == 16'h0001) exp_d = 1'b1;
                if (sec0_q != 4'd0) begin
                    sec0_d = sec0_q - 4'd1;
                end else begin
                    sec0_d = 4'd9;
                    if (sec1_q != 4'd0) begin
                        sec1_d = sec1_q - 4'd1;
                    end else begin
                        sec1_d = 4'd5;
                        if (min0_q != 4'd0) begin
                            min0_d = min0_q - 4'd1;
                        end else begin
                            min0_d = 4'd9;
                            min1_d = min1_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min1_q   <= 4'd0;
            min0_q   <= 4'd0;
            sec1_q   <= 4'd0;
            sec0_q   <= 4'd0;
            lap_q    <= 16'h0000;
            lapv_q   <= 1'b0;
            paused_q <= START_PAUSED;
            exp_q    <= 1'b0;
            lerr_q   <= 1'b0;
            pbtn_q   <= 1'b0;
            lbtn_q   <= 1'b0;
        end else begin
            min1_q   <= min1_d;
            min0_q   <= min0_d;
            sec1_q   <= sec1_d;
            sec0_q   <= sec0_d;
            lap_q    <= lap_d;
            lapv_q   <= lapv_d;
            paused_q <= paused_d;
            exp_q    <= exp_d;
            lerr_q   <= lerr_d;
            pbtn_q   <= sw.pause_btn;
            lbtn_q   <= sw.lap;
        end
    end

    assign sw.min1      = min1_q;
    assign sw.min0      = min0_q;
    assign sw.sec1      = sec1_q;
    assign sw.sec0      = sec0_q;
    assign sw.lap_time  = lap_q;
    assign sw.lap_valid = lapv_q;
    assign sw.paused    = paused_q;
    assign sw.expired   = exp_q;
    assign sw.load_err  = lerr_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Testbench for stopwatch_core: directed scenarios plus random run
// against a seconds-count reference model.
module tb_stopwatch_core;
    localparam int MM = 59;
    localparam bit SP = 1'b0;

    logic clk;
    logic reset;
    stopwatch_if sw();

    stopwatch_core #(.MIN_MAX(MM), .START_PAUSED(SP)) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: time kept as total seconds.
    int          m_t;
    logic        m_paused, m_exp, m_lapv, m_lerr, m_pprev, m_lprev;
    logic [15:0] m_lap;

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] obs_time();
        return {sw.min1, sw.min0, sw.sec1, sw.sec0};
    endfunction

    function automatic logic [35:0] obs_all();
        return {obs_time(), sw.lap_time, sw.lap_valid, sw.paused,
                sw.expired, sw.load_err};
    endfunction

    function automatic logic [35:0] exp_all();
        return {to_bcd(m_t), m_lap, m_lapv, m_paused, m_exp, m_lerr};
    endfunction

    task automatic model_reset();
        m_t = 0; m_paused = SP; m_exp = 0; m_lapv = 0;
        m_lerr = 0; m_pprev = 0; m_lprev = 0; m_lap = 16'h0;
    endtask

    task automatic model_step();
        int old_t, m, s, d3, d2, d1, d0;
        bit ok;
        old_t = m_t;
        m_lerr = 0;
        m_exp = m_exp & sw.mode;
        if (sw.lap && !m_lprev) begin
            m_lap = to_bcd(old_t);
            m_lapv = 1;
        end
        m = m_t / 60;
        s = m_t % 60;
        if (sw.load) begin
            d3 = int'(sw.preset[15:12]); d2 = int'(sw.preset[11:8]);
            d1 = int'(sw.preset[7:4]);   d0 = int'(sw.preset[3:0]);
            ok = d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 &&
                 d3 * 10 + d2 <= MM;
            if (ok) begin
                m_t = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
                m_exp = 0;
                m_lapv = 0;
            end else begin
                m_lerr = 1;
            end
        end else if (sw.adjust && sw.adj_tick) begin
            m_exp = 0;
            if (sw.select) m_t = m * 60 + (s + 1) % 60;
            else m_t = ((m + 1) % (MM + 1)) * 60 + s;
        end else if (!sw.adjust && sw.tick && !m_paused) begin
            if (!sw.mode) m_t = (m_t + 1) % ((MM + 1) * 60);
            else if (m_t == 0) m_exp = 1;
            else begin
                m_t = m_t - 1;
                if (m_t == 0) m_exp = 1;
            end
        end
        if (sw.pause_btn && !m_pprev) m_paused = !m_paused;
        m_pprev = sw.pause_btn;
        m_lprev = sw.lap;
    endtask

    // One clock: model consumes current inputs, then strobes drop.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        sw.tick = 0;
        sw.adj_tick = 0;
        sw.load = 0;
    endtask

    task automatic do_reset();
        sw.tick = 0; sw.adj_tick = 0; sw.pause_btn = 0; sw.adjust = 0;
        sw.select = 0; sw.mode = 0; sw.load = 0; sw.preset = 16'h0;
        sw.lap = 0;
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (obs_all() !== {16'h0, 16'h0, 1'b0, SP, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset got %h want %h", obs_all(),
                     {16'h0, 16'h0, 1'b0, SP, 1'b0, 1'b0});
        end
    endtask

    task automatic test_count_up();
        do_reset();
        for (int i = 0; i < 59; i++) begin sw.tick = 1; cyc(); end
        n_chk++;
        if (obs_time() !== 16'h0059) begin
            n_fail++;
            $display("FAIL up59 got %h want 0059", obs_time());
        end
        sw.tick = 1; cyc();
        n_chk++;
        if (obs_time() !== 16'h0100) begin
            n_fail++;
            $display("FAIL up60 got %h want 0100", obs_time());
        end
        sw.load = 1; sw.preset = 16'h5959; cyc();
        sw.tick = 1; cyc();
        n_chk++;
        if ({obs_time(), sw.expired} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rollover got %h/%b want 0000/0",
                     obs_time(), sw.expired);
        end
    endtask

    task automatic test_count_down();
        logic [16:0] want [3];
        want[0] = {16'h0001, 1'b0};
        want[1] = {16'h0000, 1'b1};
        want[2] = {16'h0000, 1'b1};
        do_reset();
        sw.mode = 1;
        sw.load = 1; sw.preset = 16'h0002; cyc();
        for (int i = 0; i < 3; i++) begin
            sw.tick = 1; cyc();
            n_chk++;
            if ({obs_time(), sw.expired} !== want[i]) begin
                n_fail++;
                $display("FAIL down%0d got %h/%b want %h", i,
                         obs_time(), sw.expired, want[i]);
            end
        end
        sw.mode = 0; cyc();
        n_chk++;
        if (sw.expired !== 1'b0) begin
            n_fail++;
            $display("FAIL exp_clear_mode got %b want 0", sw.expired);
        end
        sw.mode = 1;
        sw.load = 1; sw.preset = 16'h0100; cyc();
        sw.tick = 1; cyc();
        n_chk++;
        if (obs_time() !== 16'h0059) begin
            n_fail++;
            $display("FAIL borrow got %h want 0059", obs_time());
        end
    endtask

    task automatic test_pause_adjust();
        logic [15:0] want [5];
        want[0] = 16'h0058; want[1] = 16'h0059; want[2] = 16'h0000;
        want[3] = 16'h0001; want[4] = 16'h0002;
        do_reset();
        sw.load = 1; sw.preset = 16'h0056; cyc();
        sw.pause_btn = 1; sw.tick = 1; cyc();
        n_chk++;
        if ({obs_time(), sw.paused} !== {16'h0057, 1'b1}) begin
            n_fail++;
            $display("FAIL pause_tick got %h/%b want 0057/1",
                     obs_time(), sw.paused);
        end
        for (int i = 0; i < 5; i++) begin sw.tick = 1; cyc(); end
        n_chk++;
        if (obs_time() !== 16'h0057) begin
            n_fail++;
            $display("FAIL paused_hold got %h want 0057", obs_time());
        end
        sw.adjust = 1; sw.select = 1;
        for (int i = 0; i < 5; i++) begin
            sw.adj_tick = 1; cyc();
            n_chk++;
            if (obs_time() !== want[i]) begin
                n_fail++;
                $display("FAIL adj_sec%0d got %h want %h", i,
                         obs_time(), want[i]);
            end
        end
        sw.select = 0;
        sw.load = 1; sw.preset = 16'h5910; cyc();
        sw.adj_tick = 1; cyc();
        n_chk++;
        if (obs_time() !== 16'h0010) begin
            n_fail++;
            $display("FAIL adj_min_wrap got %h want 0010", obs_time());
        end
        sw.adjust = 0;
    endtask

    task automatic test_load();
        do_reset();
        sw.load = 1; sw.preset = 16'h0305; cyc();
        sw.load = 1; sw.preset = 16'h6012; cyc();
        n_chk++;
        if ({obs_time(), sw.load_err} !== {16'h0305, 1'b1}) begin
            n_fail++;
            $display("FAIL load6012 got %h/%b want 0305/1",
                     obs_time(), sw.load_err);
        end
        cyc();
        n_chk++;
        if (sw.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lerr_pulse got %b want 0", sw.load_err);
        end
        sw.load = 1; sw.preset = 16'h1A00; cyc();
        n_chk++;
        if ({obs_time(), sw.load_err} !== {16'h0305, 1'b1}) begin
            n_fail++;
            $display("FAIL load1A00 got %h/%b want 0305/1",
                     obs_time(), sw.load_err);
        end
        sw.load = 1; sw.preset = 16'h4530; cyc();
        n_chk++;
        if ({obs_time(), sw.load_err} !== {16'h4530, 1'b0}) begin
            n_fail++;
            $display("FAIL load4530 got %h/%b want 4530/0",
                     obs_time(), sw.load_err);
        end
    endtask

    task automatic test_lap();
        do_reset();
        sw.load = 1; sw.preset = 16'h1234; cyc();
        sw.lap = 1; sw.tick = 1; cyc();
        n_chk++;
        if ({sw.lap_time, obs_time(), sw.lap_valid} !==
            {16'h1234, 16'h1235, 1'b1}) begin
            n_fail++;
            $display("FAIL lap got %h/%h/%b want 1234/1235/1",
                     sw.lap_time, obs_time(), sw.lap_valid);
        end
        sw.lap = 0;
        sw.load = 1; sw.preset = 16'h0010; cyc();
        n_chk++;
        if (sw.lap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_clear got %b want 0", sw.lap_valid);
        end
        sw.lap = 1; sw.load = 1; sw.preset = 16'h0020; cyc();
        n_chk++;
        if ({sw.lap_time, sw.lap_valid, obs_time()} !==
            {16'h0010, 1'b0, 16'h0020}) begin
            n_fail++;
            $display("FAIL lap_load got %h/%b/%h want 0010/0/0020",
                     sw.lap_time, sw.lap_valid, obs_time());
        end
        sw.lap = 0;
    endtask

    task automatic test_random();
        int mm, ss;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            sw.tick = ($urandom_range(0, 1) == 1);
            sw.adj_tick = ($urandom_range(0, 3) == 0);
            sw.adjust = ($urandom_range(0, 5) == 0);
            sw.select = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 30) == 0) sw.mode = ~sw.mode;
            if ($urandom_range(0, 15) == 0) sw.pause_btn = ~sw.pause_btn;
            if ($urandom_range(0, 7) == 0) sw.lap = ~sw.lap;
            sw.load = ($urandom_range(0, 25) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sw.preset = 16'($urandom);
            end else begin
                mm = $urandom_range(0, 3);
                ss = $urandom_range(0, 59);
                sw.preset = to_bcd(mm * 60 + ss);
            end
            cyc();
            n_chk++;
            if (obs_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL rand%0d got %h want %h", i,
                         obs_all(), exp_all());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sw.load = 1; sw.preset = 16'h0741; cyc();
        sw.lap = 1; sw.tick = 1; cyc();
        n_chk++;
        if (obs_time() !== 16'h0742) begin
            n_fail++;
            $display("FAIL pre_areset got %h want 0742", obs_time());
        end
        #2;
        reset = 0;
        #1;
        n_chk++;
        if (obs_all() !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h want 0", obs_all());
        end
        sw.lap = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        n_chk++;
        if ({sw.paused, obs_time()} !== {SP, 16'h0000}) begin
            n_fail++;
            $display("FAIL post_reset got %b/%h want %b/0000",
                     sw.paused, obs_time(), SP);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1;
        test_reset();
        test_count_up();
        test_count_down();
        test_pause_adjust();
        test_load();
        test_lap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
